// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall unit port bundle: ID-stage hazard inputs, pipeline
// control outputs and performance counters.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [2:0]       id_pcsrc;
    logic             id_regwr;
    logic [4:0]       id_wraddr;
    logic             id_memrd;
    logic             ex_br_taken;
    logic             ext_stall;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_pcsrc,
        output id_regwr, id_wraddr, id_memrd, ex_br_taken, ext_stall,
        input  pc_en, ifid_en, ifid_flush, idex_flush,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_pcsrc,
        input  id_regwr, id_wraddr, id_memrd, ex_br_taken, ext_stall,
        output pc_en, ifid_en, ifid_flush, idex_flush,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Detects load-use and load-to-jr hazards that forwarding cannot cover,
// drives PC/IF/ID/ID/EX stall and flush controls, counts stalls and flushes.
module hazard_stall_unit #(
    parameter int         CNT_W    = 16,
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input logic                clk,
    input logic                reset,
    hazard_stall_unit_if.slave hs
);
    logic             ex_wr_q, ex_wr_d;
    logic [4:0]       ex_dst_q, ex_dst_d;
    logic             ex_ld_q, ex_ld_d;
    logic             mem_wr_q, mem_wr_d;
    logic [4:0]       mem_dst_q, mem_dst_d;
    logic             mem_ld_q, mem_ld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_load;
    logic mem_load;
    logic rs_hit_ex;
    logic rt_hit_ex;
    logic rs_hit_mem;
    logic lu_haz;
    logic jr_haz;
    logic haz;
    logic jump;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic stall_inc;
    logic flush_inc;

    always_comb begin
        ex_load    = ex_ld_q & ex_wr_q;
        mem_load   = mem_ld_q & mem_wr_q;
        rs_hit_ex  = (hs.id_rs != ZERO_REG) && (hs.id_rs == ex_dst_q);
        rt_hit_ex  = (hs.id_rt != ZERO_REG) && (hs.id_rt == ex_dst_q);
        rs_hit_mem = (hs.id_rs != ZERO_REG) && (hs.id_rs == mem_dst_q);
        lu_haz     = hs.id_valid & ex_load &
                     ((hs.id_use_rs & rs_hit_ex) |
                      (hs.id_use_rt & rt_hit_ex));
        // jr needs its target in ID, so a load in EX or MEM both block it
        jr_haz     = hs.id_valid & (hs.id_pcsrc == 3'd3) &
                     ((ex_load & rs_hit_ex) | (mem_load & rs_hit_mem));
        haz        = lu_haz | jr_haz;
        jump       = hs.id_valid &
                     ((hs.id_pcsrc == 3'd2) | (hs.id_pcsrc == 3'd3));
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hs.ext_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
        end else if (hs.ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
        end else if (haz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
        end else if (jump) begin
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
        end
    end

    always_comb begin
        ex_wr_d   = ex_wr_q;
        ex_dst_d  = ex_dst_q;
        ex_ld_d   = ex_ld_q;
        mem_wr_d  = mem_wr_q;
        mem_dst_d = mem_dst_q;
        mem_ld_d  = mem_ld_q;
        if (!hs.ext_stall) begin
            mem_wr_d  = ex_wr_q;
            mem_dst_d = ex_dst_q;
            mem_ld_d  = ex_ld_q;
            if (hs.id_valid && !idex_flush) begin
                ex_wr_d  = hs.id_regwr;
                ex_dst_d = hs.id_wraddr;
                ex_ld_d  = hs.id_memrd;
            end else begin
                ex_wr_d  = 1'b0;
                ex_dst_d = 5'd0;
                ex_ld_d  = 1'b0;
            end
        end
    end

    // saturating counters: stop at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_wr_q     <= 1'b0;
            ex_dst_q    <= 5'd0;
            ex_ld_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dst_q   <= 5'd0;
            mem_ld_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_wr_q     <= ex_wr_d;
            ex_dst_q    <= ex_dst_d;
            ex_ld_q     <= ex_ld_d;
            mem_wr_q    <= mem_wr_d;
            mem_dst_q   <= mem_dst_d;
            mem_ld_q    <= mem_ld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hs.pc_en      = pc_en;
    assign hs.ifid_en    = ifid_en;
    assign hs.ifid_flush = ifid_flush;
    assign hs.idex_flush = idex_flush;
    assign hs.stall_cnt  = stall_cnt_q;
    assign hs.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus a randomized run
// against an in-flight-instruction model; a 4-bit instance covers saturation.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(16)) bi ();
    hazard_stall_unit_if #(.CNT_W(4))  si ();

    hazard_stall_unit #(.CNT_W(16), .ZERO_REG(5'd0)) dut (
        .clk(clk), .reset(reset), .hs(bi)
    );
    hazard_stall_unit #(.CNT_W(4), .ZERO_REG(5'd0)) dut_s (
        .clk(clk), .reset(reset), .hs(si)
    );

    assign si.id_valid    = bi.id_valid;
    assign si.id_rs       = bi.id_rs;
    assign si.id_rt       = bi.id_rt;
    assign si.id_use_rs   = bi.id_use_rs;
    assign si.id_use_rt   = bi.id_use_rt;
    assign si.id_pcsrc    = bi.id_pcsrc;
    assign si.id_regwr    = bi.id_regwr;
    assign si.id_wraddr   = bi.id_wraddr;
    assign si.id_memrd    = bi.id_memrd;
    assign si.ex_br_taken = bi.ex_br_taken;
    assign si.ext_stall   = bi.ext_stall;

    typedef struct {
        bit       wr;
        bit [4:0] dst;
        bit       ld;
    } slot_t;

    // pipe[0] = instruction now in EX, pipe[1] = instruction now in MEM
    slot_t pipe[2];
    int m_st, m_fl, m_sts, m_fls;
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0]  exp_o;
    logic [15:0] exp_st, exp_fl;
    logic [3:0]  exp_sts, exp_fls;

    function automatic bit ld_at(int d, bit [4:0] r);
        return pipe[d].ld && pipe[d].wr && pipe[d].dst == r && r != 5'd0;
    endfunction

    function automatic int sat(int x, int mx);
        return (x >= mx) ? mx : x + 1;
    endfunction

    function automatic logic [3:0] outs();
        return {bi.pc_en, bi.ifid_en, bi.ifid_flush, bi.idex_flush};
    endfunction

    function automatic logic [3:0] outs_s();
        return {si.pc_en, si.ifid_en, si.ifid_flush, si.idex_flush};
    endfunction

    // Drive one cycle of inputs and predict this cycle's outputs
    task automatic step(input bit rst, v, input bit [4:0] rs, rt,
                        input bit urs, urt, input bit [2:0] pc,
                        input bit wr, input bit [4:0] dst,
                        input bit ld, br, ext);
        bit lu, jr;
        @(negedge clk);
        reset = rst;
        bi.id_valid = v;     bi.id_rs = rs;        bi.id_rt = rt;
        bi.id_use_rs = urs;  bi.id_use_rt = urt;   bi.id_pcsrc = pc;
        bi.id_regwr = wr;    bi.id_wraddr = dst;   bi.id_memrd = ld;
        bi.ex_br_taken = br; bi.ext_stall = ext;
        #1;
        exp_st = m_st[15:0];  exp_fl = m_fl[15:0];
        exp_sts = m_sts[3:0]; exp_fls = m_fls[3:0];
        lu = v && ((urs && ld_at(0, rs)) || (urt && ld_at(0, rt)));
        jr = v && pc == 3'd3 && (ld_at(0, rs) || ld_at(1, rs));
        if (rst) begin
            exp_o = 4'b0011;
            pipe[0] = '{0, 0, 0};
            pipe[1] = '{0, 0, 0};
            m_st = 0; m_fl = 0; m_sts = 0; m_fls = 0;
        end else if (ext) begin
            exp_o = 4'b0000;
        end else begin
            if (br) begin
                exp_o = 4'b1111;
                m_fl = sat(m_fl, 65535); m_fls = sat(m_fls, 15);
            end else if (lu || jr) begin
                exp_o = 4'b0001;
                m_st = sat(m_st, 65535); m_sts = sat(m_sts, 15);
            end else if (v && (pc == 3'd2 || pc == 3'd3)) begin
                exp_o = 4'b1110;
                m_fl = sat(m_fl, 65535); m_fls = sat(m_fls, 15);
            end else begin
                exp_o = 4'b1100;
            end
            pipe[1] = pipe[0];
            if (v && !exp_o[0]) pipe[0] = '{wr, dst, ld};
            else                pipe[0] = '{0, 0, 0};
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw(input bit [4:0] d);
        step(0, 1, 0, 0, 0, 0, 0, 1, d, 1, 0, 0);
    endtask

    task automatic use_rs(input bit [4:0] r, input bit br, ext);
        step(0, 1, r, 0, 1, 0, 0, 1, 5'd9, 0, br, ext);
    endtask

    task automatic jr(input bit [4:0] r, input bit rst);
        step(rst, 1, r, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (outs() !== 4'b0011) begin n_bad++; $display("FAIL reset_outs got %b want 0011", outs()); end
        step(1, 1, 5'd3, 0, 1, 0, 3'd3, 1, 5'd3, 1, 1, 0);
        n_cmp++; if (outs() !== 4'b0011) begin n_bad++; $display("FAIL reset_prio got %b want 0011", outs()); end
        n_cmp++; if ({bi.stall_cnt, bi.flush_cnt} !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", {bi.stall_cnt, bi.flush_cnt}); end
        idle();
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL reset_idle got %b want 1100", outs()); end
    endtask

    task automatic test_load_use();
        do_reset();
        lw(5'd8);
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL lu_lw got %b want 1100", outs()); end
        use_rs(5'd8, 0, 0);
        n_cmp++; if (outs() !== 4'b0001) begin n_bad++; $display("FAIL lu_stall got %b want 0001", outs()); end
        use_rs(5'd8, 0, 0);
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL lu_go got %b want 1100", outs()); end
        idle();
        n_cmp++; if (bi.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", bi.stall_cnt); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        lw(5'd0);
        use_rs(5'd0, 0, 0);
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL zero_nostall got %b want 1100", outs()); end
        idle();
        n_cmp++; if (bi.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL zero_cnt got %0d want 0", bi.stall_cnt); end
    endtask

    task automatic test_jr();
        do_reset();
        lw(5'd31);
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b0001) begin n_bad++; $display("FAIL jr_stall1 got %b want 0001", outs()); end
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b0001) begin n_bad++; $display("FAIL jr_stall2 got %b want 0001", outs()); end
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b1110) begin n_bad++; $display("FAIL jr_go got %b want 1110", outs()); end
        idle();
        n_cmp++; if (bi.stall_cnt !== 16'd2) begin n_bad++; $display("FAIL jr_stall_cnt got %0d want 2", bi.stall_cnt); end
        n_cmp++; if (bi.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL jr_flush_cnt got %0d want 1", bi.flush_cnt); end
    endtask

    task automatic test_jr_gap();
        do_reset();
        lw(5'd31);
        idle();
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b0001) begin n_bad++; $display("FAIL jrgap_stall got %b want 0001", outs()); end
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b1110) begin n_bad++; $display("FAIL jrgap_go got %b want 1110", outs()); end
    endtask

    task automatic test_branch();
        do_reset();
        lw(5'd8);
        use_rs(5'd8, 1, 0);
        n_cmp++; if (outs() !== 4'b1111) begin n_bad++; $display("FAIL br_outs got %b want 1111", outs()); end
        idle();
        n_cmp++; if (bi.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_flush_cnt got %0d want 1", bi.flush_cnt); end
        n_cmp++; if (bi.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL br_stall_cnt got %0d want 0", bi.stall_cnt); end
    endtask

    task automatic test_ext_stall();
        do_reset();
        lw(5'd8);
        for (int i = 0; i < 3; i++) begin
            use_rs(5'd8, 0, 1);
            n_cmp++; if (outs() !== 4'b0000) begin n_bad++; $display("FAIL ext_outs[%0d] got %b want 0000", i, outs()); end
            n_cmp++; if (bi.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL ext_cnt[%0d] got %0d want 0", i, bi.stall_cnt); end
        end
        use_rs(5'd8, 0, 0);
        n_cmp++; if (outs() !== 4'b0001) begin n_bad++; $display("FAIL ext_release got %b want 0001", outs()); end
        use_rs(5'd8, 0, 0);
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL ext_go got %b want 1100", outs()); end
        idle();
        n_cmp++; if (bi.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL ext_stall_cnt got %0d want 1", bi.stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        lw(5'd31);
        jr(5'd31, 1);
        n_cmp++; if (outs() !== 4'b0011) begin n_bad++; $display("FAIL rmid_outs got %b want 0011", outs()); end
        idle();
        n_cmp++; if (outs() !== 4'b1100) begin n_bad++; $display("FAIL rmid_after got %b want 1100", outs()); end
        n_cmp++; if ({bi.stall_cnt, bi.flush_cnt} !== 32'd0) begin n_bad++; $display("FAIL rmid_cnt got %h want 0", {bi.stall_cnt, bi.flush_cnt}); end
        jr(5'd31, 0);
        n_cmp++; if (outs() !== 4'b1110) begin n_bad++; $display("FAIL rmid_jr got %b want 1110", outs()); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            lw(5'd8);
            use_rs(5'd8, 0, 0);
        end
        for (int i = 0; i < 20; i++) use_rs(5'd1, 1, 0);
        idle();
        n_cmp++; if (si.stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_stall got %h want F", si.stall_cnt); end
        n_cmp++; if (si.flush_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_flush got %h want F", si.flush_cnt); end
        n_cmp++; if (bi.stall_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_wide got %0d want 20", bi.stall_cnt); end
        lw(5'd8);
        use_rs(5'd8, 0, 0);
        n_cmp++; if (outs_s() !== 4'b0001) begin n_bad++; $display("FAIL sat_stall_out got %b want 0001", outs_s()); end
        idle();
        n_cmp++; if (si.stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_hold got %h want F", si.stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
            n_cmp++; if (outs() !== exp_o) begin n_bad++; $display("FAIL rnd_outs[%0d] got %b want %b", i, outs(), exp_o); end
            n_cmp++; if (outs_s() !== exp_o) begin n_bad++; $display("FAIL rnd_outs_s[%0d] got %b want %b", i, outs_s(), exp_o); end
            n_cmp++; if ({bi.stall_cnt, bi.flush_cnt} !== {exp_st, exp_fl}) begin n_bad++; $display("FAIL rnd_cnt[%0d] got %h want %h", i, {bi.stall_cnt, bi.flush_cnt}, {exp_st, exp_fl}); end
            n_cmp++; if ({si.stall_cnt, si.flush_cnt} !== {exp_sts, exp_fls}) begin n_bad++; $display("FAIL rnd_cnt_s[%0d] got %h want %h", i, {si.stall_cnt, si.flush_cnt}, {exp_sts, exp_fls}); end
        end
    endtask

    initial begin
        reset = 1'b1;
        m_st = 0; m_fl = 0; m_sts = 0; m_fls = 0;
        pipe[0] = '{0, 0, 0};
        pipe[1] = '{0, 0, 0};
        test_reset();
        test_load_use();
        test_zero_reg();
        test_jr();
        test_jr_gap();
        test_branch();
        test_ext_stall();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
